fnd_scan_controller: RTL and testbench

- Parametrised N-digit multiplexed 7-segment scan controller for common-anode displays with active-low anodes and segments.
- Takes packed 4-bit digit codes plus per-digit decimal-point, blink and blank masks, and a 4-bit brightness level.
- Scans the digits round-robin at a programmable slot rate and PWM-dims each slot.
- Sits between the time/stopwatch datapath and the board pins, replacing the fixed 4-digit scanner.

---
 rtl/fnd_scan_controller.sv | 167 ++++++++++++++++
 tb/tb_fnd_scan_controller.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_controller.sv
// Multiplexed common-anode 7-segment scan controller: round-robin digit scan with
// PWM dimming, frame-synchronous input snapshot, blink and leading-zero suppression.
module fnd_scan_controller #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SUB_DIV      = 6250,
  parameter int unsigned BLINK_FRAMES = 125,
  parameter int unsigned HEX_EN       = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digit_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   fnd_digit,
  output logic [7:0]              fnd_data,
  output logic                    frame_start
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned SUB_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [SUB_W-1:0]        sub_cnt_q, sub_cnt_d;
  logic [3:0]              phase_q, phase_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BLK_W-1:0]        blink_cnt_q, blink_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic                    init_q;
  logic [4*NUM_DIGITS-1:0] digit_q;
  logic [NUM_DIGITS-1:0]   dp_q, blink_q, blank_q;
  logic                    lz_q;
  logic [NUM_DIGITS-1:0]   fnd_digit_q, fnd_digit_d;
  logic [7:0]              fnd_data_q, fnd_data_d;
  logic                    frame_start_q;

  logic                    sub_tick, slot_end, frame_wrap, load;
  logic [NUM_DIGITS-1:0]   lzs, onehot;
  logic                    zero_run;
  logic [3:0]              sel_code;
  logic                    sel_dp, sel_blink, sel_blank, sel_lzs, slot_on;

  function automatic logic [6:0] seg7(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    if (HEX_EN == 0 && code > 4'h9) s = 7'h7F;
    return s;
  endfunction

  always_comb begin
    sub_tick      = (sub_cnt_q == SUB_W'(SUB_DIV - 1));
    slot_end      = sub_tick && (phase_q == 4'hF);
    frame_wrap    = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
    load          = init_q || frame_wrap;

    sub_cnt_d     = sub_tick ? '0 : sub_cnt_q + SUB_W'(1);
    phase_d       = sub_tick ? phase_q + 4'd1 : phase_q;
    idx_d         = idx_q;
    if (slot_end) idx_d = frame_wrap ? '0 : idx_q + IDX_W'(1);

    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (load) begin
      if (blink_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + BLK_W'(1);
      end
    end
  end

  // Walk from the most significant digit down; suppression stops at the first
  // non-zero code or lit decimal point. Digit 0 always shows.
  always_comb begin
    lzs      = '0;
    zero_run = lz_q;
    for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
      zero_run = zero_run && (digit_q[4*(NUM_DIGITS-1-k) +: 4] == 4'h0)
                          && !dp_q[NUM_DIGITS-1-k];
      lzs[NUM_DIGITS-1-k] = zero_run;
    end
  end

  always_comb begin
    onehot    = '0;
    sel_code  = '0;
    sel_dp    = 1'b0;
    sel_blink = 1'b0;
    sel_blank = 1'b0;
    sel_lzs   = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        onehot[i] = 1'b1;
        sel_code  = digit_q[4*i +: 4];
        sel_dp    = dp_q[i];
        sel_blink = blink_q[i];
        sel_blank = blank_q[i];
        sel_lzs   = lzs[i];
      end
    end
    slot_on     = !sel_blank && !(sel_blink && blink_phase_q) && !sel_lzs &&
                  (phase_q <= brightness) && (phase_q != 4'hF);
    fnd_digit_d = slot_on ? ~onehot : '1;
    fnd_data_d  = slot_on ? {~sel_dp, seg7(sel_code)} : 8'hFF;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sub_cnt_q     <= '0;
      phase_q       <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      init_q        <= 1'b1;
      digit_q       <= '0;
      dp_q          <= '0;
      blink_q       <= '0;
      blank_q       <= '0;
      lz_q          <= 1'b0;
      fnd_digit_q   <= '1;
      fnd_data_q    <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      sub_cnt_q     <= sub_cnt_d;
      phase_q       <= phase_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      init_q        <= 1'b0;
      if (load) begin
        digit_q <= digit_in;
        dp_q    <= dp_in;
        blink_q <= blink_en;
        blank_q <= blank_in;
        lz_q    <= lz_en;
      end
      fnd_digit_q   <= fnd_digit_d;
      fnd_data_q    <= fnd_data_d;
      frame_start_q <= load;
    end
  end

  assign fnd_digit   = fnd_digit_q;
  assign fnd_data    = fnd_data_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller: directed and random stimulus checked every cycle
// against a time-arithmetic reference model of the scan, snapshot and blink rules.
module tb_fnd_scan_controller;

  localparam int unsigned N     = 4;
  localparam int unsigned SUB   = 2;
  localparam int unsigned BF    = 2;
  localparam int unsigned SLOT  = 16 * SUB;
  localparam int unsigned FRAME = SLOT * N;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic           clk = 1'b0;
  logic           reset_n;
  logic [4*N-1:0] digit_in;
  logic [N-1:0]   dp_in, blink_en, blank_in;
  logic           lz_en;
  logic [3:0]     brightness;
  logic [N-1:0]   fnd_digit, nh_digit;
  logic [7:0]     fnd_data, nh_data;
  logic           frame_start, nh_fs;

  always #5 clk = ~clk;

  fnd_scan_controller #(.NUM_DIGITS(N), .SUB_DIV(SUB), .BLINK_FRAMES(BF), .HEX_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .digit_in(digit_in), .dp_in(dp_in),
    .blink_en(blink_en), .blank_in(blank_in), .lz_en(lz_en), .brightness(brightness),
    .fnd_digit(fnd_digit), .fnd_data(fnd_data), .frame_start(frame_start));

  fnd_scan_controller #(.NUM_DIGITS(N), .SUB_DIV(SUB), .BLINK_FRAMES(BF), .HEX_EN(0)) dut_nohex (
    .clk(clk), .reset_n(reset_n), .digit_in(digit_in), .dp_in(dp_in),
    .blink_en(blink_en), .blank_in(blank_in), .lz_en(lz_en), .brightness(brightness),
    .fnd_digit(nh_digit), .fnd_data(nh_data), .frame_start(nh_fs));

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Model state: cycles since reset release, frames loaded, and the bench's own snapshot.
  int unsigned    s;
  int unsigned    n_loads;
  logic [4*N-1:0] m_digit;
  logic [N-1:0]   m_dp, m_blink, m_blank;
  logic           m_lz;
  logic [N-1:0]   exp_dig;
  logic [7:0]     exp_dat, exp_dat_nh;
  logic           exp_fs;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at cycle %0d: observed %h, expected %h", tag, s, obs, exp);
    end
  endtask

  task automatic model_reset();
    s = 0; n_loads = 0;
    m_digit = '0; m_dp = '0; m_blink = '0; m_blank = '0; m_lz = 1'b0;
  endtask

  task automatic model_edge();
    int unsigned ph, id;
    logic [3:0]   code;
    logic [4*N-1:0] upper;
    logic [N-1:0] oh, dp_upper;
    bit           sup, bp, on;
    ph       = (s / SUB) % 16;
    id       = (s / SLOT) % N;
    upper    = m_digit >> (4 * id);
    dp_upper = m_dp >> id;
    code     = upper[3:0];
    sup      = m_lz && (id > 0) && (upper == '0) && (dp_upper == '0);
    bp       = ((n_loads / BF) % 2) == 1;
    on       = !m_blank[id] && !(m_blink[id] && bp) && !sup &&
               (ph <= 32'(brightness)) && (ph != 15);
    oh       = '0;
    oh[id]   = 1'b1;
    exp_dig    = on ? ~oh : '1;
    exp_dat    = on ? {~m_dp[id], SEG_TBL[code]} : 8'hFF;
    exp_dat_nh = on ? {~m_dp[id], (code > 4'h9) ? 7'h7F : SEG_TBL[code]} : 8'hFF;
    exp_fs     = (s == 0) || ((s % FRAME) == FRAME - 1);
    if (exp_fs) begin
      n_loads++;
      m_digit = digit_in; m_dp = dp_in; m_blink = blink_en;
      m_blank = blank_in; m_lz = lz_en;
    end
    s++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("anode", 16'(fnd_digit), 16'(exp_dig));
    check("segdata", 16'(fnd_data), 16'(exp_dat));
    check("frame_start", 16'(frame_start), 16'(exp_fs));
    check("nohex_anode", 16'(nh_digit), 16'(exp_dig));
    check("nohex_segdata", 16'(nh_data), 16'(exp_dat_nh));
    check("nohex_frame_start", 16'(nh_fs), 16'(exp_fs));
  endtask

  task automatic run(input int unsigned n);
    repeat (n) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_anode"}, 16'(fnd_digit), 16'hF);
    check({tag, "_segdata"}, 16'(fnd_data), 16'hFF);
    check({tag, "_frame_start"}, 16'(frame_start), 16'h0);
    check({tag, "_nohex_segdata"}, 16'(nh_data), 16'hFF);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time bound, observed running, required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    reset_n = 1'b0;
    digit_in = 16'h1234; dp_in = 4'b0100; blink_en = '0; blank_in = '0;
    lz_en = 1'b0; brightness = 4'd15;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_hold");
    #4 reset_n = 1'b1;

    // First frames at full duty, then live brightness changes.
    run(2 * FRAME);
    brightness = 4'd0;  run(FRAME);
    brightness = 4'd7;  run(FRAME);
    brightness = 4'd15;

    // Hex letters: lit on the HEX_EN=1 instance, blank on the other.
    digit_in = 16'hABCF; dp_in = '0;
    run(2 * FRAME);

    // Leading-zero suppression, then a decimal point that stops it.
    lz_en = 1'b1; digit_in = 16'h0050;
    run(2 * FRAME);
    dp_in = 4'b1000;
    run(2 * FRAME);

    // Blink on the low digits with mid-frame input changes.
    lz_en = 1'b0; dp_in = '0; blink_en = 4'b0011; digit_in = 16'h1234;
    run(FRAME / 2);
    digit_in = 16'h5678;
    run(FRAME);
    digit_in = 16'h9ABC;
    run(4 * FRAME);

    // Random inputs changed at random points in the frame.
    repeat (24) begin
      run($urandom_range(10, 90));
      digit_in   = 16'($urandom) >> (4 * $urandom_range(0, 4));
      dp_in      = 4'($urandom) & 4'($urandom);
      blink_en   = 4'($urandom);
      blank_in   = 4'($urandom) & 4'($urandom) & 4'($urandom);
      lz_en      = 1'($urandom_range(0, 1));
      brightness = 4'($urandom);
    end

    // Asynchronous reset between clock edges.
    run(37);
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    check_reset_outputs("async_reset_hold");
    #4 reset_n = 1'b1;
    run(FRAME + 40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
